wam_mole: RTL and testbench

Mole field engine for the Whac-A-Mole game. Each game tick it may spawn a mole in a pseudo-randomly chosen hole, using the difficulty pair `age`/`rto` from the hardness controller. It ages live moles and clears them on expiry or on a player hit, and keeps a two-digit BCD score. It also returns the one-cycle `cout0` carry that the hardness controller uses to step difficulty up, which closes the difficulty loop from the consumer side.

---
 rtl/wam_pkg.sv | 14 +
 rtl/wam_lfsr.sv | 24 ++
 rtl/wam_mole.sv | 142 ++++++++++++++
 tb/tb_wam_mole.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared constants and types for the Whac-A-Mole field engine.
package wam_pkg;

  localparam logic [15:0] WAM_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] WAM_LFSR_SEED = 16'hACE1;
  localparam int          WAM_MISS_MAX  = 255;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running 16-bit right-shifting Galois LFSR, reloaded with the seed on clr.
module wam_lfsr
  import wam_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) state_d = state_d ^ WAM_LFSR_TAPS;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= WAM_LFSR_SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/wam_mole.sv
// Mole field engine: spawn, ageing, hit scoring and BCD score with carry out.
// Optional saturating expiry counter on the miss port when WAM_MISS_EN is defined.
module wam_mole
  import wam_pkg::*;
#(
  parameter int NHOLE = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick,
  input  logic [3:0]       age,
  input  logic [7:0]       rto,
  input  logic [NHOLE-1:0] hit,
  output logic [NHOLE-1:0] mole,
  output logic [3:0]       score_lo,
  output logic [3:0]       score_hi,
  output logic             cout0
`ifdef WAM_MISS_EN
  ,
  output logic [7:0]       miss
`endif
);

  localparam int LW = $clog2(NHOLE);

  logic [15:0]      lfsr;
  logic [LW-1:0]    cand;
  logic [7:0]       rnd;
  logic             unused_lfsr;

  logic [3:0]       life_q [NHOLE];
  logic [3:0]       life_d [NHOLE];
  logic [NHOLE-1:0] mole_q, mole_d;
  logic [NHOLE-1:0] expire;
  bcd_t             lo_q, lo_d, hi_q, hi_d;
  logic             cout0_q, cout0_d;

  logic             win_valid;
  logic [LW-1:0]    win_idx;
  logic [3:0]       age_eff;
  logic             spawn_ok;

  wam_lfsr u_lfsr (
    .clk   (clk),
    .clr   (clr),
    .state (lfsr)
  );

  assign cand        = lfsr[LW-1:0];
  assign rnd         = lfsr[15:8];
  assign unused_lfsr = ^lfsr[7:LW];

  // Lowest-index live hit scores; scan from the top so the lowest index wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NHOLE - 1; i >= 0; i--) begin
      if (hit[i] && mole_q[i]) begin
        win_valid = 1'b1;
        win_idx   = LW'(i);
      end
    end
  end

  assign age_eff  = (age == 4'd0) ? 4'd1 : age;
  assign spawn_ok = tick && (rnd < rto) && (life_q[cand] == 4'd0) && !hit[cand];

  // A hit clears before ageing can expire it; spawns only land on empty holes.
  always_comb begin
    for (int i = 0; i < NHOLE; i++) begin
      life_d[i] = life_q[i];
      expire[i] = 1'b0;
      if (win_valid && (win_idx == LW'(i))) begin
        life_d[i] = 4'd0;
      end else if (tick && (life_q[i] != 4'd0)) begin
        life_d[i] = life_q[i] - 4'd1;
        expire[i] = (life_q[i] == 4'd1);
      end
      if (spawn_ok && (cand == LW'(i))) life_d[i] = age_eff;
      mole_d[i] = (life_d[i] != 4'd0);
    end
  end

  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    cout0_d = 1'b0;
    if (win_valid) begin
      lo_d = bcd_inc(lo_q);
      if (lo_q == 4'd9) begin
        hi_d    = bcd_inc(hi_q);
        cout0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NHOLE; i++) life_q[i] <= 4'd0;
      mole_q  <= '0;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      cout0_q <= 1'b0;
    end else begin
      life_q  <= life_d;
      mole_q  <= mole_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cout0_q <= cout0_d;
    end
  end

  assign mole     = mole_q;
  assign score_lo = lo_q;
  assign score_hi = hi_q;
  assign cout0    = cout0_q;

`ifdef WAM_MISS_EN
  logic [7:0] miss_q, miss_d;
  logic [4:0] n_exp;
  logic [8:0] miss_sum;

  // Several holes can expire on one tick, so add the count before saturating.
  always_comb begin
    n_exp = '0;
    for (int i = 0; i < NHOLE; i++) n_exp = n_exp + 5'(expire[i]);
    miss_sum = {1'b0, miss_q} + 9'(n_exp);
    miss_d   = (miss_sum > 9'(WAM_MISS_MAX)) ? 8'(WAM_MISS_MAX) : miss_sum[7:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) miss_q <= 8'd0;
    else     miss_q <= miss_d;
  end

  assign miss = miss_q;
`else
  logic unused_expire;
  assign unused_expire = |expire;
`endif

endmodule

// File: tb/tb_wam_mole.sv
// Bench for wam_mole: fixed vector table, directed corner sequences and random
// stimulus checked against a behavioural game model.
module tb_wam_mole;

  logic        clk = 1'b0;
  logic        clr;
  logic        tick;
  logic [3:0]  age;
  logic [7:0]  rto;
  logic [15:0] hit;
  logic [15:0] mole;
  logic [3:0]  score_lo, score_hi;
  logic        cout0;
`ifdef WAM_MISS_EN
  logic [7:0]  miss;
`endif

  int n_vec = 0;
  int n_err = 0;

  wam_mole #(.NHOLE(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .tick     (tick),
    .age      (age),
    .rto      (rto),
    .hit      (hit),
    .mole     (mole),
    .score_lo (score_lo),
    .score_hi (score_hi),
    .cout0    (cout0)
`ifdef WAM_MISS_EN
    ,
    .miss     (miss)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr;
  int          m_life [16];
  int          m_score;
  int          m_miss;
  logic [15:0] m_mole;
  logic        m_cout;

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_score = 0;
    m_miss  = 0;
    m_mole  = '0;
    m_cout  = 1'b0;
    for (int i = 0; i < 16; i++) m_life[i] = 0;
  endtask

  task automatic model_step();
    int win;
    int nl [16];
    int cand;
    int rnd;
    win = -1;
    for (int i = 0; i < 16; i++)
      if (hit[i] && m_life[i] > 0 && win < 0) win = i;
    for (int i = 0; i < 16; i++) begin
      nl[i] = m_life[i];
      if (i == win) nl[i] = 0;
      else if (tick && m_life[i] > 0) begin
        nl[i] = m_life[i] - 1;
        if (nl[i] == 0 && m_miss < 255) m_miss++;
      end
    end
    cand = int'(m_lfsr) % 16;
    rnd  = int'(m_lfsr) / 256;
    if (tick && rnd < int'(rto) && m_life[cand] == 0 && !hit[cand])
      nl[cand] = (age == 4'd0) ? 1 : int'(age);
    m_cout = 1'b0;
    if (win >= 0) begin
      m_cout  = (m_score % 10 == 9);
      m_score = (m_score + 1) % 100;
    end
    for (int i = 0; i < 16; i++) begin
      m_life[i] = nl[i];
      m_mole[i] = (nl[i] != 0);
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".mole"}, mole, m_mole);
    chk({nm, ".lo"}, 16'(score_lo), 16'(m_score % 10));
    chk({nm, ".hi"}, 16'(score_hi), 16'(m_score / 10));
    chk({nm, ".cout0"}, 16'(cout0), 16'(m_cout));
`ifdef WAM_MISS_EN
    chk({nm, ".miss"}, 16'(miss), 16'(m_miss));
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic t, input logic [3:0] a, input logic [7:0] r, input logic [15:0] h);
    tick = t;
    age  = a;
    rto  = r;
    hit  = h;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    drive(1'b0, 4'd0, 8'd0, 16'h0);
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic spawn_at(input int h);
    for (int k = 0; k < 400 && m_life[h] == 0; k++) begin
      drive(m_lfsr[3:0] == 4'(h), 4'd15, 8'hFF, 16'h0);
      cycle();
      chk_model("spawn_at");
    end
    chk("spawn_at.live", 16'(mole[h]), 16'd1);
    drive(1'b0, 4'd15, 8'hFF, 16'h0);
  endtask

  task automatic score_one(output logic saw_cout);
    int lo;
    for (int k = 0; k < 50 && m_mole == 16'h0; k++) begin
      drive(1'b1, 4'd15, 8'hFF, 16'h0);
      cycle();
    end
    lo = 0;
    for (int i = 15; i >= 0; i--) if (m_mole[i]) lo = i;
    drive(1'b0, 4'd15, 8'hFF, 16'(1) << lo);
    cycle();
    chk_model("score_one");
    saw_cout = cout0;
    drive(1'b0, 4'd15, 8'h0, 16'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        t;
    logic [3:0]  a;
    logic [7:0]  r;
    logic [15:0] h;
    logic [15:0] e_mole;
    logic [3:0]  e_lo;
    logic        e_cout;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic saw;
    int   ncout;
    int   prev;

    // LFSR runs ACE1, E270, 7138, 389C, 1C4E, 0E27, B313, ED89, C2C4 from reset.
    tbl[0]  = '{1'b1, 4'd3, 8'hFF, 16'h0000, 16'h0002, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'd3, 8'hFF, 16'h0000, 16'h0002, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'd3, 8'h00, 16'h0000, 16'h0002, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'd3, 8'h00, 16'h0002, 16'h0000, 4'd1, 1'b0};
    tbl[4]  = '{1'b1, 4'd0, 8'hFF, 16'h0000, 16'h4000, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 4'd0, 8'h00, 16'h0000, 16'h0000, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 8'h00, 16'h4000, 16'h0000, 4'd1, 1'b0};
    tbl[7]  = '{1'b1, 4'd5, 8'h10, 16'h0000, 16'h0000, 4'd1, 1'b0};
    tbl[8]  = '{1'b1, 4'd5, 8'hC3, 16'h0000, 16'h0010, 4'd1, 1'b0};
    tbl[9]  = '{1'b1, 4'd5, 8'h00, 16'h0010, 16'h0000, 4'd2, 1'b0};
    tbl[10] = '{1'b0, 4'd5, 8'h00, 16'h0000, 16'h0000, 4'd2, 1'b0};

    clr = 1'b1;
    drive(1'b0, 4'd0, 8'd0, 16'h0);
    model_reset();
    #1;
    chk("reset.mole", mole, 16'h0);
    chk("reset.lo", 16'(score_lo), 16'h0);
    chk("reset.cout0", 16'(cout0), 16'h0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    for (int v = 0; v < 11; v++) begin
      drive(tbl[v].t, tbl[v].a, tbl[v].r, tbl[v].h);
      cycle();
      chk($sformatf("tbl%0d.mole", v), mole, tbl[v].e_mole);
      chk($sformatf("tbl%0d.lo", v), 16'(score_lo), 16'(tbl[v].e_lo));
      chk($sformatf("tbl%0d.cout0", v), 16'(cout0), 16'(tbl[v].e_cout));
    end
    chk_model("tbl_end");

    // Spawn with age 3 expires after three more ticks.
    do_reset();
    drive(1'b1, 4'd3, 8'hFF, 16'h0);
    cycle();
    chk("spawn.first", mole, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'd3, 8'h00, 16'h0);
      cycle();
      chk_model("spawn.age");
    end
    chk("spawn.expired", mole, 16'h0);

    // rto = 0 never spawns.
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 8'h00, 16'h0);
      cycle();
      chk("nospawn.mole", mole, 16'h0);
    end

    // Hit at hole 5, then a hit on the now-empty hole.
    spawn_at(5);
    prev = m_score;
    drive(1'b0, 4'd15, 8'h00, 16'h0020);
    cycle();
    chk("hit5.mole5", 16'(mole[5]), 16'd0);
    chk("hit5.lo", 16'(score_lo), 16'((prev + 1) % 10));
    chk_model("hit5");
    cycle();
    chk("hit_empty.lo", 16'(score_lo), 16'((prev + 1) % 10));
    chk_model("hit_empty");

    // Priority: holes 2 and 9 hit together, only 2 scores.
    spawn_at(2);
    spawn_at(9);
    prev = m_score;
    drive(1'b0, 4'd15, 8'h00, 16'h0204);
    cycle();
    chk("prio.mole2", 16'(mole[2]), 16'd0);
    chk("prio.mole9", 16'(mole[9]), 16'd1);
    chk("prio.lo", 16'(score_lo), 16'((prev + 1) % 10));
    chk_model("prio");

    // Carry chain through 100 scoring hits.
    do_reset();
    ncout = 0;
    for (int n = 1; n <= 100; n++) begin
      score_one(saw);
      if (saw) ncout++;
      if (n == 10) begin
        chk("carry10.lo", 16'(score_lo), 16'd0);
        chk("carry10.hi", 16'(score_hi), 16'd1);
        chk("carry10.cout0", 16'(cout0), 16'd1);
        cycle();
        chk("carry10.cout0_drop", 16'(cout0), 16'd0);
      end
    end
    chk("carry100.lo", 16'(score_lo), 16'd0);
    chk("carry100.hi", 16'(score_hi), 16'd0);
    chk("carry100.ncout", 16'(ncout), 16'd10);

    // Async reset mid-cycle with score 37 and a live mole.
    for (int n = 0; n < 37; n++) score_one(saw);
    chk("pre_reset.score", 16'({score_hi, score_lo}), 16'h0037);
    spawn_at(int'(m_lfsr[3:0]));
    @(posedge clk);
    #3;
    clr = 1'b1;
    drive(1'b1, 4'd3, 8'hFF, 16'hFFFF);
    #1;
    model_reset();
    chk("areset.mole", mole, 16'h0);
    chk("areset.lo", 16'(score_lo), 16'h0);
    chk("areset.hi", 16'(score_hi), 16'h0);
    chk("areset.cout0", 16'(cout0), 16'h0);
`ifdef WAM_MISS_EN
    chk("areset.miss", 16'(miss), 16'h0);
`endif
    @(negedge clk);
    clr = 1'b0;
    drive(1'b1, 4'd3, 8'hFF, 16'h0);
    cycle();
    chk("post_reset.spawn", mole, 16'h0002);
    chk_model("post_reset");

    // Random play against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] h;
      h = '0;
      if ($urandom_range(0, 3) == 0) begin
        if (m_mole != 0 && $urandom_range(0, 1) == 1) h = m_mole & 16'($urandom);
        else h = 16'(1) << $urandom_range(0, 15);
        if ($urandom_range(0, 5) == 0) h = h | (16'(1) << $urandom_range(0, 15));
      end
      drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 8'($urandom), h);
      cycle();
      chk_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
